viterbi_word_packer: RTL and testbench
======================================

Name: viterbi_word_packer

Overview:
Downstream stage of the Viterbi core. Consumes the decoded serial bit stream (one bit per valid cycle, never stalled) and packs it into WORD_W-bit words. Words are buffered in a small FIFO and presented on a valid/ready output port. Bits arriving while the FIFO is full are dropped and flagged, never back-pressured, because the core cannot stall.

Parameters:
WORD_W, 8, output word width in bits (>=2)
FIFO_DEPTH, 4, number of buffered words (power of 2, >=2)
CNT_W, $clog2(WORD_W), width of the bit counter
LVL_W, $clog2(FIFO_DEPTH)+1, width of the fill-level output

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
valid_serial_i  in  1  decoded bit valid, from core valid_serial_o
data_serial_i  in  1  decoded bit, from core data_serial_o
flush_i  in  1  single-cycle pulse: emit the partial word, zero-padded
ready_i  in  1  consumer ready
data_o  out  WORD_W  head-of-FIFO word
valid_o  out  1  head word valid
partial_o  out  1  head word was flushed before it was full
overflow_o  out  1  sticky flag: one or more words were dropped
clear_ovf_i  in  1  clears overflow_o
level_o  out  LVL_W  FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: bit counter=0, shift register=0, FIFO empty. data_o=0, valid_o=0, partial_o=0, overflow_o=0, level_o=0. A reset mid-word or mid-burst discards all state, with no flush.
- Bit order: LSB-first. The first bit received lands in data_o[0] and the last in data_o[WORD_W-1].
- Accept: each cycle with valid_serial_i=1 accepts one bit. The counter increments and wraps from WORD_W-1 to 0.
- Word completion: the bit that brings the count to WORD_W assembles shift register plus incoming bit combinationally. The word is written to the FIFO on that same edge with partial=0. It is visible (valid_o=1 if FIFO was empty) in the cycle after that edge: 1-cycle latency.
- Flush: on flush_i=1 with count>0 after accounting for any same-cycle bit, the accumulated bits are written with upper bits=0 and partial=1, and the counter resets to 0.
  - If flush_i coincides with a completing bit, the full word is written with partial=0. No extra word is generated.
  - Flush with count=0 is a no-op.
- Output: first-word-fall-through. valid_o = !empty and data_o/partial_o = head. A pop occurs when valid_o & ready_i. data_o holds stable while valid_o & !ready_i.
- Simultaneous push and pop:
  - When full, allowed: the pop frees the slot and level is unchanged.
  - When empty, the pop is impossible (valid_o=0) and only the push occurs.
- Overflow: a push while full with no same-cycle pop drops the new word and sets overflow_o=1 on that edge. The counter still resets and FIFO content is unchanged.
- clear_ovf_i clears overflow_o next edge. If it coincides with a new overflow, set wins.
- level_o is registered and equals the number of stored words, 0..FIFO_DEPTH.
- No combinational path from ready_i to any output other than through registered state.

Decomposition:
- Shared package viterbi_pkg: WORD_W and FIFO_DEPTH defaults, and the FIFO entry layout {partial, word}, width WORD_W+1.
- One sub-module, vit_word_fifo: synchronous FWFT FIFO, parameter DATA_W=WORD_W+1 and DEPTH.
  - Ports: push, pop, din, dout, empty, full, level.
  - Pointers are LVL_W wide with an extra wrap bit.
- The packer itself holds the counter, shift register, flush logic and overflow flag.

Test Plan:
- Reset, then 16 valid bits 1,0,1,1,0,0,0,0, 1,1,1,1,0,0,0,0 with ready_i=1 -> words 0x0D then 0x0F, each valid_o one cycle after its 8th bit, partial_o=0.
- 3 bits 1,1,0 then flush_i -> one word 0x03 with partial_o=1; next 8 bits assemble from bit 0.
- flush_i in the same cycle as the 8th bit of 0xA5 -> exactly one word 0xA5, partial_o=0, level_o peaks at 1.
- ready_i=0, 5 full words streamed -> level_o reaches 4, 5th word dropped, overflow_o=1. Then ready_i=1 -> 4 original words out in order, level_o=0. clear_ovf_i -> overflow_o=0.
- FIFO full, 8th bit of a new word arrives in the same cycle as a pop -> no overflow, level_o stays 4, new word last in order.
- Assert rst_n low mid-word (count=5) and with 2 words queued -> all outputs 0 asynchronously. After release, the next 8 bits form a clean word.

Source files
------------

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared defaults and FIFO entry layout for the Viterbi word packer
package viterbi_pkg;

  localparam int WORD_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  // Each FIFO entry is {partial, word}: the partial flag sits just above the word bits.
  localparam int ENTRY_W_DEF    = WORD_W_DEF + 1;

  typedef struct packed {
    logic                  partial;
    logic [WORD_W_DEF-1:0] word;
  } vit_entry_t;

endpackage

// File: rtl/vit_word_fifo.sv
// rtl/vit_word_fifo.sv - synchronous first-word-fall-through FIFO with registered fill level
module vit_word_fifo
  import viterbi_pkg::*;
#(
  parameter int DATA_W = ENTRY_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [LVL_W-1:0]  level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LVL_W-1:0]  wr_q, wr_d;
  logic [LVL_W-1:0]  rd_q, rd_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push_ok, pop_ok;

  // Pointers carry an extra wrap bit so full and empty differ only in the MSB.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem[rd_q[AW-1:0]];
  assign level_o = level_q;

  always_comb begin
    pop_ok  = pop_i && !empty_o;
    push_ok = push_i && (!full_o || pop_ok);
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (push_ok) wr_d = wr_q + LVL_W'(1);
    if (pop_ok)  rd_d = rd_q + LVL_W'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LVL_W'(1);
    else if (pop_ok && !push_ok) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // A push into a full FIFO with a same-cycle pop reuses the head slot being vacated.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/viterbi_word_packer.sv
// rtl/viterbi_word_packer.sv - packs the decoded serial bit stream into LSB-first words
module viterbi_word_packer
  import viterbi_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = $clog2(WORD_W),
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_serial_i,
  input  logic              data_serial_i,
  input  logic              flush_i,
  input  logic              ready_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  output logic              partial_o,
  output logic              overflow_o,
  input  logic              clear_ovf_i,
  output logic [LVL_W-1:0]  level_o
);

  localparam int               ENTRY_W  = WORD_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  sr_q, sr_d;
  logic [WORD_W-1:0]  word_asm;
  logic               ovf_q, ovf_d;
  logic               complete, do_flush, push_req;
  logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;

  always_comb begin
    word_asm = sr_q;
    if (valid_serial_i) word_asm[cnt_q] = data_serial_i;

    complete = valid_serial_i && (cnt_q == CNT_LAST);
    // A flush only produces a word if at least one bit is held, counting this cycle's bit.
    do_flush = flush_i && !complete && (valid_serial_i || (cnt_q != '0));
    push_req = complete || do_flush;

    fifo_pop  = !fifo_empty && ready_i;
    fifo_push = push_req && (!fifo_full || fifo_pop);
    fifo_din  = {do_flush, word_asm};

    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (push_req) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (valid_serial_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      sr_d  = word_asm;
    end

    ovf_d = ovf_q;
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
    else if (clear_ovf_i)                   ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
      ovf_q <= ovf_d;
    end
  end

  vit_word_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (level_o)
  );

  // Stale memory contents are masked so an empty FIFO always presents zeros.
  assign valid_o    = !fifo_empty;
  assign data_o     = fifo_empty ? '0 : fifo_dout[WORD_W-1:0];
  assign partial_o  = !fifo_empty && fifo_dout[WORD_W];
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_viterbi_word_packer.sv
// tb/tb_viterbi_word_packer.sv - directed self-checking bench for viterbi_word_packer
module tb_viterbi_word_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_serial_i, data_serial_i, flush_i, ready_i, clear_ovf_i;
  logic [7:0] data_o;
  logic       valid_o, partial_o, overflow_o;
  logic [2:0] level_o;

  int checks = 0;
  int errors = 0;

  viterbi_word_packer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_serial_i (valid_serial_i),
    .data_serial_i  (data_serial_i),
    .flush_i        (flush_i),
    .ready_i        (ready_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .partial_o      (partial_o),
    .overflow_o     (overflow_o),
    .clear_ovf_i    (clear_ovf_i),
    .level_o        (level_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fl);
    valid_serial_i = 1'b1;
    data_serial_i  = b;
    flush_i        = fl;
    tick();
    valid_serial_i = 1'b0;
    data_serial_i  = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i], 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid_serial_i = 1'b0; data_serial_i = 1'b0;
    flush_i = 1'b0; ready_i = 1'b1; clear_ovf_i = 1'b0;
    #12;
    check("rst_data",    32'(data_o),     32'h0);
    check("rst_valid",   32'(valid_o),    32'h0);
    check("rst_partial", 32'(partial_o),  32'h0);
    check("rst_ovf",     32'(overflow_o), 32'h0);
    check("rst_level",   32'(level_o),    32'h0);
    rst_n = 1'b1;
    tick();

    // bits 1,0,1,1,0,0,0,0 -> 0x0D ; bits 1,1,1,1,0,0,0,0 -> 0x0F
    send_bits(8'h0D, 7);
    check("w1_not_yet",  32'(valid_o),   32'h0);
    send_bits(8'h80 & 8'h0D, 0);
    send_bit(1'b0, 1'b0);
    check("w1_valid",    32'(valid_o),   32'h1);
    check("w1_data",     32'(data_o),    32'h0D);
    check("w1_partial",  32'(partial_o), 32'h0);
    check("w1_level",    32'(level_o),   32'h1);
    send_bits(8'h0F, 8);
    check("w2_valid",    32'(valid_o),   32'h1);
    check("w2_data",     32'(data_o),    32'h0F);
    check("w2_partial",  32'(partial_o), 32'h0);
    check("w2_level",    32'(level_o),   32'h1);
    tick();
    check("w2_drained",  32'(level_o),   32'h0);

    // partial flush of bits 1,1,0 -> 0x03
    send_bits(8'h03, 3);
    check("fl_pre_valid", 32'(valid_o), 32'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("fl_valid",   32'(valid_o),   32'h1);
    check("fl_data",    32'(data_o),    32'h03);
    check("fl_partial", 32'(partial_o), 32'h1);
    send_bits(8'h5A, 8);
    check("after_fl_data",    32'(data_o),    32'h5A);
    check("after_fl_partial", 32'(partial_o), 32'h0);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("fl_empty_noop", 32'(level_o), 32'h0);

    // flush coinciding with the completing bit of 0xA5
    send_bits(8'hA5, 7);
    send_bit(1'b1, 1'b1);
    check("flc_data",    32'(data_o),    32'hA5);
    check("flc_partial", 32'(partial_o), 32'h0);
    check("flc_level",   32'(level_o),   32'h1);
    ready_i = 1'b0;
    tick();
    check("flc_no_extra", 32'(level_o), 32'h1);
    ready_i = 1'b1;
    tick();
    check("flc_drained", 32'(level_o), 32'h0);

    // overflow: 5 words with consumer stalled
    ready_i = 1'b0;
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    send_bits(8'h44, 8);
    check("ovf_level4",  32'(level_o),    32'h4);
    check("ovf_not_yet", 32'(overflow_o), 32'h0);
    send_bits(8'h55, 8);
    check("ovf_level",   32'(level_o),    32'h4);
    check("ovf_set",     32'(overflow_o), 32'h1);
    check("ovf_hold",    32'(data_o),     32'h11);
    ready_i = 1'b1;
    check("ovf_out0", 32'(data_o), 32'h11);
    tick();
    check("ovf_out1", 32'(data_o), 32'h22);
    tick();
    check("ovf_out2", 32'(data_o), 32'h33);
    tick();
    check("ovf_out3", 32'(data_o), 32'h44);
    tick();
    check("ovf_empty_level", 32'(level_o),    32'h0);
    check("ovf_empty_valid", 32'(valid_o),    32'h0);
    check("ovf_sticky",      32'(overflow_o), 32'h1);
    clear_ovf_i = 1'b1;
    tick();
    clear_ovf_i = 1'b0;
    check("ovf_cleared", 32'(overflow_o), 32'h0);

    // full FIFO, completing bit arrives together with a pop
    ready_i = 1'b0;
    send_bits(8'h61, 8);
    send_bits(8'h62, 8);
    send_bits(8'h63, 8);
    send_bits(8'h64, 8);
    send_bits(8'h65, 7);
    ready_i = 1'b1;
    send_bit(1'b0, 1'b0);
    ready_i = 1'b0;
    check("pp_level", 32'(level_o),    32'h4);
    check("pp_ovf",   32'(overflow_o), 32'h0);
    check("pp_head",  32'(data_o),     32'h62);
    ready_i = 1'b1;
    tick();
    check("pp_out1", 32'(data_o), 32'h63);
    tick();
    check("pp_out2", 32'(data_o), 32'h64);
    tick();
    check("pp_out3", 32'(data_o), 32'h65);
    tick();
    check("pp_drained", 32'(level_o), 32'h0);

    // asynchronous reset mid-word with words queued
    ready_i = 1'b0;
    send_bits(8'h71, 8);
    send_bits(8'h72, 8);
    send_bits(8'h1F, 5);
    check("ar_pre_level", 32'(level_o), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_data",    32'(data_o),     32'h0);
    check("ar_valid",   32'(valid_o),    32'h0);
    check("ar_partial", 32'(partial_o),  32'h0);
    check("ar_ovf",     32'(overflow_o), 32'h0);
    check("ar_level",   32'(level_o),    32'h0);
    tick();
    rst_n = 1'b1;
    ready_i = 1'b1;
    tick();
    send_bits(8'hC3, 8);
    check("ar_clean_data",    32'(data_o),    32'hC3);
    check("ar_clean_partial", 32'(partial_o), 32'h0);
    check("ar_clean_level",   32'(level_o),   32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
